// File: rtl/cfu_pim_mac_seq.sv
// Bit-serial processing-in-memory MAC CFU: weight array times activation bit-planes,
// column popcounts shift-accumulated, with a valid/ready command/response handshake.
module cfu_pim_mac_seq #(
  parameter int unsigned PWIDTH = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned AWIDTH = $clog2(DEPTH),
  parameter int unsigned ABITS  = 8,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned FWIDTH = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [FWIDTH-1:0] cmd_payload_function_id,
  input  logic [31:0]       cmd_payload_inputs_0,
  input  logic [31:0]       cmd_payload_inputs_1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_payload_response_ok,
  output logic [DWIDTH-1:0] rsp_payload_outputs_0
);

  localparam int unsigned RawW = PWIDTH + ABITS + AWIDTH + 1;
  localparam int unsigned SW   = (RawW > DWIDTH) ? RawW : DWIDTH;
  localparam int unsigned CW   = AWIDTH + 1;
  localparam int unsigned KW   = (ABITS > 1) ? $clog2(ABITS) : 1;

  localparam logic [2:0] OpWrite = 3'd0;
  localparam logic [2:0] OpRead  = 3'd1;
  localparam logic [2:0] OpLoad  = 3'd2;
  localparam logic [2:0] OpMac   = 3'd3;
  localparam logic [2:0] OpClear = 3'd4;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e              state_q;
  logic [PWIDTH-1:0]   weight_q [DEPTH];
  logic [ABITS-1:0]    act_q    [DEPTH];
  logic [DWIDTH-1:0]   acc_q;
  logic [SW-1:0]       partial_q;
  logic [KW-1:0]       k_q, n_q;
  logic                accum_q;
  logic                rsp_valid_q, rsp_ok_q;
  logic [DWIDTH-1:0]   rsp_data_q;

  logic [2:0]          opcode;
  logic [AWIDTH-1:0]   row;
  logic                in_range;
  logic [4:0]          n_req;
  logic [KW-1:0]       last_idx;
  logic [SW-1:0]       step;
  logic [SW-1:0]       acc_sum;
  logic [DWIDTH-1:0]   acc_next;
  logic                unused_fid;

  assign opcode     = cmd_payload_function_id[2:0];
  assign row        = cmd_payload_inputs_0[AWIDTH-1:0];
  assign in_range   = cmd_payload_inputs_0 < 32'(DEPTH);
  assign n_req      = cmd_payload_inputs_0[4:0];
  assign unused_fid = ^cmd_payload_function_id[FWIDTH-1:4];

  assign cmd_ready               = (state_q == StIdle);
  assign rsp_valid               = rsp_valid_q;
  assign rsp_payload_response_ok = rsp_ok_q;
  assign rsp_payload_outputs_0   = rsp_data_q;

  always_comb begin
    if (n_req == 5'd0 || 32'(n_req) > ABITS) begin
      last_idx = KW'(ABITS - 1);
    end else begin
      last_idx = KW'(n_req - 5'd1);
    end
  end

  // One bit-plane: each column's popcount of active word lines, weighted by column and plane.
  always_comb begin
    logic [CW-1:0] cnt;
    step = '0;
    for (int i = 0; i < PWIDTH; i++) begin
      cnt = '0;
      for (int j = 0; j < DEPTH; j++) begin
        cnt = cnt + CW'(weight_q[j][i] & act_q[j][k_q]);
      end
      step = step + (SW'(cnt) << i);
    end
    step = step << k_q;
  end

  assign acc_sum  = (accum_q ? SW'(acc_q) : '0) + partial_q + step;
  assign acc_next = acc_sum[DWIDTH-1:0];

  // Weight storage has no reset.
  always_ff @(posedge clk) begin
    if (!reset && state_q == StIdle && cmd_valid && opcode == OpWrite && in_range) begin
      weight_q[row] <= cmd_payload_inputs_1[PWIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rsp_valid_q <= 1'b0;
      rsp_ok_q    <= 1'b0;
      rsp_data_q  <= '0;
      acc_q       <= '0;
      partial_q   <= '0;
      k_q         <= '0;
      n_q         <= '0;
      accum_q     <= 1'b0;
      for (int j = 0; j < DEPTH; j++) act_q[j] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            unique case (opcode)
              OpWrite: begin
                rsp_ok_q   <= in_range;
                rsp_data_q <= in_range ? DWIDTH'(cmd_payload_inputs_1[PWIDTH-1:0]) : '0;
                rsp_valid_q <= 1'b1;
                state_q    <= StResp;
              end
              OpRead: begin
                rsp_ok_q   <= in_range;
                rsp_data_q <= in_range ? DWIDTH'(weight_q[row]) : '0;
                rsp_valid_q <= 1'b1;
                state_q    <= StResp;
              end
              OpLoad: begin
                if (in_range) act_q[row] <= cmd_payload_inputs_1[ABITS-1:0];
                rsp_ok_q   <= in_range;
                rsp_data_q <= in_range ? DWIDTH'(cmd_payload_inputs_1[ABITS-1:0]) : '0;
                rsp_valid_q <= 1'b1;
                state_q    <= StResp;
              end
              OpMac: begin
                n_q       <= last_idx;
                k_q       <= '0;
                partial_q <= '0;
                accum_q   <= cmd_payload_function_id[3];
                state_q   <= StExec;
              end
              OpClear: begin
                for (int j = 0; j < DEPTH; j++) act_q[j] <= '0;
                acc_q      <= '0;
                rsp_ok_q   <= 1'b1;
                rsp_data_q <= '0;
                rsp_valid_q <= 1'b1;
                state_q    <= StResp;
              end
              default: begin
                rsp_ok_q   <= 1'b0;
                rsp_data_q <= '0;
                rsp_valid_q <= 1'b1;
                state_q    <= StResp;
              end
            endcase
          end
        end
        StExec: begin
          partial_q <= partial_q + step;
          k_q       <= k_q + 1'b1;
          if (k_q == n_q) begin
            acc_q       <= acc_next;
            rsp_data_q  <= acc_next;
            rsp_ok_q    <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cfu_pim_mac_seq.sv
// Directed, table-driven bench for cfu_pim_mac_seq with hand-computed expectations.
module tb_cfu_pim_mac_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  fid;
  logic [31:0] in0, in1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_ok;
  logic [31:0] rsp_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cfu_pim_mac_seq dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (fid),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_response_ok (rsp_ok),
    .rsp_payload_outputs_0   (rsp_data)
  );

  typedef struct packed {
    logic [9:0]  fid;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] exp_data;
    logic        exp_ok;
    logic [7:0]  exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at #1 after a posedge; returns once rsp_valid is seen (or the bound expires).
  task automatic send(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                      output int lat, output logic [31:0] d, output logic ok);
    int w;
    fid = f; in0 = a; in1 = b; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    d = rsp_data; ok = rsp_ok;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] d;
    logic ok;
    int seen;

    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; fid = '0; in0 = '0; in1 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_data", rsp_data, 32'd0);
    chk("reset_ok", 32'(rsp_ok), 32'd0);

    // Weights are undefined after power-up; zero them all first.
    for (int r = 0; r < 64; r++) begin
      send(10'd0, 32'(r), 32'd0, lat, d, ok);
      consume();
    end

    //             fid     in0     in1          data         ok  lat
    vecs.push_back({10'h000, 32'd3,  32'h0000_00A5, 32'h0000_00A5, 1'b1, 8'd1});
    vecs.push_back({10'h001, 32'd3,  32'd0,         32'h0000_00A5, 1'b1, 8'd1});
    vecs.push_back({10'h000, 32'd3,  32'd0,         32'd0,         1'b1, 8'd1});
    vecs.push_back({10'h000, 32'd0,  32'd5,         32'd5,         1'b1, 8'd1});
    vecs.push_back({10'h000, 32'd1,  32'd7,         32'd7,         1'b1, 8'd1});
    vecs.push_back({10'h002, 32'd0,  32'd3,         32'd3,         1'b1, 8'd1});
    vecs.push_back({10'h002, 32'd1,  32'd2,         32'd2,         1'b1, 8'd1});
    vecs.push_back({10'h003, 32'd0,  32'd0,         32'd29,        1'b1, 8'd9});
    vecs.push_back({10'h003, 32'd1,  32'd0,         32'd5,         1'b1, 8'd2});
    vecs.push_back({10'h00B, 32'd8,  32'd0,         32'd34,        1'b1, 8'd9});
    vecs.push_back({10'h000, 32'd64, 32'hFFFF_FFFF, 32'd0,         1'b0, 8'd1});
    vecs.push_back({10'h001, 32'd0,  32'd0,         32'd5,         1'b1, 8'd1});
    vecs.push_back({10'h006, 32'd0,  32'd0,         32'd0,         1'b0, 8'd1});
    vecs.push_back({10'h003, 32'd20, 32'd0,         32'd29,        1'b1, 8'd9});
    vecs.push_back({10'h3F5, 32'd1,  32'd1,         32'd0,         1'b0, 8'd1});
    vecs.push_back({10'h002, 32'd64, 32'd9,         32'd0,         1'b0, 8'd1});
    vecs.push_back({10'h3FB, 32'd0,  32'd0,         32'd58,        1'b1, 8'd9});
    vecs.push_back({10'h004, 32'd0,  32'd0,         32'd0,         1'b1, 8'd1});
    vecs.push_back({10'h00B, 32'd8,  32'd0,         32'd0,         1'b1, 8'd9});
    vecs.push_back({10'h002, 32'd1,  32'h1FF,       32'hFF,        1'b1, 8'd1});
    vecs.push_back({10'h003, 32'd0,  32'd0,         32'd1785,      1'b1, 8'd9});

    foreach (vecs[v]) begin
      send(vecs[v].fid, vecs[v].in0, vecs[v].in1, lat, d, ok);
      chk($sformatf("vec%0d_data", v), d, vecs[v].exp_data);
      chk($sformatf("vec%0d_ok", v), 32'(ok), 32'(vecs[v].exp_ok));
      chk($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
      consume();
    end

    // Backpressure: READ row 0 held for 5 cycles while a READ of row 1 is pending.
    send(10'h001, 32'd0, 32'd0, lat, d, ok);
    chk("bp_first_data", d, 32'd5);
    fid = 10'h001; in0 = 32'd1; cmd_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid_%0d", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_data_%0d", c), rsp_data, 32'd5);
      chk($sformatf("bp_ready_%0d", c), 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_release_valid", 32'(rsp_valid), 32'd0);
    chk("bp_release_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("bp_second_valid", 32'(rsp_valid), 32'd1);
    chk("bp_second_data", rsp_data, 32'd7);
    consume();

    // Reset in the 3rd EXEC cycle of a MAC aborts it and clears the activations.
    fid = 10'h003; in0 = 32'd0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort_data", rsp_data, 32'd0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    send(10'h00B, 32'd0, 32'd0, lat, d, ok);
    chk("post_reset_mac_data", d, 32'd0);
    chk("post_reset_mac_lat", 32'(lat), 32'd9);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
